// File: rtl/axil_crossbar_resp_if.sv
// Bus bundle for the AXI-lite crossbar R-channel return path: reply commands,
// per-master R inputs, the slave-side R output and the queue-depth status.
interface axil_crossbar_resp_if #(
  parameter int M_COUNT             = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int CMD_FIFO_ADDR_WIDTH = 2
);
  localparam int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  logic [CL_M_COUNT-1:0]            s_rc_select;
  logic                             s_rc_decerr;
  logic                             s_rc_valid;
  logic                             s_rc_ready;
  logic [M_COUNT*DATA_WIDTH-1:0]    m_axil_rdata;
  logic [M_COUNT*2-1:0]             m_axil_rresp;
  logic [M_COUNT-1:0]               m_axil_rvalid;
  logic [M_COUNT-1:0]               m_axil_rready;
  logic [DATA_WIDTH-1:0]            s_axil_rdata;
  logic [1:0]                       s_axil_rresp;
  logic                             s_axil_rvalid;
  logic                             s_axil_rready;
  logic [CMD_FIFO_ADDR_WIDTH:0]     cmd_count;

  // The return-path block itself sits on the slave modport.
  modport slave (
    input  s_rc_select, s_rc_decerr, s_rc_valid, m_axil_rdata, m_axil_rresp,
           m_axil_rvalid, s_axil_rready,
    output s_rc_ready, m_axil_rready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
           cmd_count
  );

  modport master (
    output s_rc_select, s_rc_decerr, s_rc_valid, m_axil_rdata, m_axil_rresp,
           m_axil_rvalid, s_axil_rready,
    input  s_rc_ready, m_axil_rready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
           cmd_count
  );
endinterface

// File: rtl/axil_crossbar_resp.sv
// R-channel return path for one crossbar slave port: queues reply commands in
// order, muxes the selected master's R beat out, and synthesises DECERR locally.
module axil_crossbar_resp #(
  parameter int M_COUNT             = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int CMD_FIFO_ADDR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_crossbar_resp_if.slave  bus
);
  localparam int CL_M_COUNT = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int AW         = CMD_FIFO_ADDR_WIDTH;
  localparam int DEPTH      = 2**AW;

  logic [CL_M_COUNT-1:0]  r_sel_mem [DEPTH];
  logic [DEPTH-1:0]       r_dec_mem;
  logic [AW:0]            r_wr_ptr, r_rd_ptr;
  logic                   r_rvalid;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [1:0]             r_rresp;

  logic                   w_full, w_empty, w_push, w_pop;
  logic [CL_M_COUNT-1:0]  w_head_sel;
  logic                   w_head_dec, w_sel_oor, w_head_err;
  logic                   w_out_free, w_mvalid;
  logic [M_COUNT-1:0]     w_rready;
  logic [DATA_WIDTH-1:0]  w_mdata;
  logic [1:0]             w_mresp;

  // Extra wrap bit distinguishes full from empty when addresses match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push     = bus.s_rc_valid && !w_full;
  assign w_head_sel = r_sel_mem[r_rd_ptr[AW-1:0]];
  assign w_head_dec = r_dec_mem[r_rd_ptr[AW-1:0]];

  generate
    if (M_COUNT < (1 << CL_M_COUNT)) begin : g_sel_range
      assign w_sel_oor = (int'(w_head_sel) >= M_COUNT);
    end else begin : g_sel_full
      assign w_sel_oor = 1'b0;
    end
  endgenerate

  assign w_head_err = w_head_dec || w_sel_oor;
  assign w_out_free = !r_rvalid || bus.s_axil_rready;
  assign w_mvalid   = bus.m_axil_rvalid[w_head_sel];
  assign w_mdata    = bus.m_axil_rdata[int'(w_head_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_mresp    = bus.m_axil_rresp[int'(w_head_sel)*2 +: 2];
  assign w_pop      = !w_empty && w_out_free && (w_head_err || w_mvalid);

  always_comb begin
    w_rready = '0;
    if (!w_empty && !w_head_err && w_out_free) w_rready[w_head_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sel_mem[r_wr_ptr[AW-1:0]] <= bus.s_rc_select;
      r_dec_mem[r_wr_ptr[AW-1:0]] <= bus.s_rc_decerr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rvalid <= 1'b1;
        r_rdata  <= w_head_err ? '0 : w_mdata;
        r_rresp  <= w_head_err ? 2'b11 : w_mresp;
      end else if (bus.s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bus.s_rc_ready    = !w_full;
  assign bus.m_axil_rready = w_rready;
  assign bus.s_axil_rvalid = r_rvalid;
  assign bus.s_axil_rdata  = r_rdata;
  assign bus.s_axil_rresp  = r_rresp;
  assign bus.cmd_count     = r_wr_ptr - r_rd_ptr;
endmodule

// File: tb/tb_axil_crossbar_resp.sv
// Directed bench for axil_crossbar_resp: M_COUNT=4, 32-bit data, 4-deep command queue.
module tb_axil_crossbar_resp;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  axil_crossbar_resp_if #(.M_COUNT(4), .DATA_WIDTH(32), .CMD_FIFO_ADDR_WIDTH(2)) bus ();

  axil_crossbar_resp #(.M_COUNT(4), .DATA_WIDTH(32), .CMD_FIFO_ADDR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] d, input logic [1:0] r);
    bus.m_axil_rdata[i*32 +: 32] = d;
    bus.m_axil_rresp[i*2 +: 2]   = r;
  endtask

  initial begin
    rst               = 1'b1;
    bus.s_rc_select   = '0;
    bus.s_rc_decerr   = 1'b0;
    bus.s_rc_valid    = 1'b0;
    bus.m_axil_rdata  = '0;
    bus.m_axil_rresp  = '0;
    bus.m_axil_rvalid = '0;
    bus.s_axil_rready = 1'b1;
    #3;
    chk("rst_rvalid", bus.s_axil_rvalid, 1'b0);
    chk("rst_rdata",  bus.s_axil_rdata, 32'h0);
    chk("rst_rresp",  bus.s_axil_rresp, 2'b00);
    chk("rst_rcready", bus.s_rc_ready, 1'b1);
    chk("rst_count",  bus.cmd_count, 3'd0);
    chk("rst_mready", bus.m_axil_rready, 4'b0000);
    tick();
    rst = 1'b0;

    // 1: single routed beat from master 2
    bus.s_rc_select = 2'd2; bus.s_rc_valid = 1'b1;
    tick();
    bus.s_rc_valid = 1'b0;
    #1;
    chk("t1_count1", bus.cmd_count, 3'd1);
    set_m(2, 32'hDEADBEEF, 2'b00);
    bus.m_axil_rvalid = 4'b0100;
    #1;
    chk("t1_mready", bus.m_axil_rready, 4'b0100);
    tick();
    bus.m_axil_rvalid = 4'b0000;
    #1;
    chk("t1_rvalid", bus.s_axil_rvalid, 1'b1);
    chk("t1_rdata",  bus.s_axil_rdata, 32'hDEADBEEF);
    chk("t1_rresp",  bus.s_axil_rresp, 2'b00);
    chk("t1_count0", bus.cmd_count, 3'd0);
    tick();
    chk("t1_clear",  bus.s_axil_rvalid, 1'b0);

    // 2: locally generated DECERR
    bus.s_rc_select = 2'd0; bus.s_rc_decerr = 1'b1; bus.s_rc_valid = 1'b1;
    tick();
    bus.s_rc_valid = 1'b0; bus.s_rc_decerr = 1'b0;
    #1;
    chk("t2_rvalid_n1", bus.s_axil_rvalid, 1'b0);
    chk("t2_mready_n1", bus.m_axil_rready, 4'b0000);
    chk("t2_count_n1",  bus.cmd_count, 3'd1);
    tick();
    chk("t2_rvalid_n2", bus.s_axil_rvalid, 1'b1);
    chk("t2_rdata",     bus.s_axil_rdata, 32'h0);
    chk("t2_rresp",     bus.s_axil_rresp, 2'b11);
    chk("t2_mready_n2", bus.m_axil_rready, 4'b0000);
    tick();
    chk("t2_rvalid_n3", bus.s_axil_rvalid, 1'b0);

    // 3: ordering, m3 ready early but must wait behind m1
    bus.s_rc_select = 2'd1; bus.s_rc_valid = 1'b1;
    tick();
    bus.s_rc_select = 2'd3;
    tick();
    bus.s_rc_valid = 1'b0;
    set_m(3, 32'h33333333, 2'b01);
    bus.m_axil_rvalid = 4'b1000;
    #1;
    chk("t3_mready_a", bus.m_axil_rready, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_rvalid", bus.s_axil_rvalid, 1'b0);
      chk("t3_hold_mready", bus.m_axil_rready, 4'b0010);
    end
    set_m(1, 32'h11111111, 2'b00);
    bus.m_axil_rvalid = 4'b1010;
    tick();
    bus.m_axil_rvalid = 4'b1000;
    #1;
    chk("t3_first_data", bus.s_axil_rdata, 32'h11111111);
    chk("t3_first_vld",  bus.s_axil_rvalid, 1'b1);
    chk("t3_mready_b",   bus.m_axil_rready, 4'b1000);
    tick();
    bus.m_axil_rvalid = 4'b0000;
    chk("t3_second_data", bus.s_axil_rdata, 32'h33333333);
    chk("t3_second_resp", bus.s_axil_rresp, 2'b01);
    chk("t3_count0",      bus.cmd_count, 3'd0);
    tick();
    chk("t3_clear", bus.s_axil_rvalid, 1'b0);

    // 4: fill the queue with the output stalled
    bus.s_axil_rready = 1'b0;
    bus.s_rc_select = 2'd0; bus.s_rc_valid = 1'b1;
    tick(); tick(); tick();
    chk("t4_count3",   bus.cmd_count, 3'd3);
    chk("t4_ready3",   bus.s_rc_ready, 1'b1);
    tick();
    chk("t4_count4",   bus.cmd_count, 3'd4);
    chk("t4_full",     bus.s_rc_ready, 1'b0);
    tick();
    chk("t4_count_5th", bus.cmd_count, 3'd4);
    set_m(0, 32'hA0A0A0A0, 2'b00);
    bus.m_axil_rvalid = 4'b0001;
    #1;
    chk("t4_mready", bus.m_axil_rready, 4'b0001);
    tick();
    chk("t4_no_pushthru", bus.cmd_count, 3'd3);
    chk("t4_ready_back",  bus.s_rc_ready, 1'b1);
    bus.s_rc_valid = 1'b0;
    set_m(0, 32'hB0B0B0B0, 2'b00);
    #1;
    chk("t4_stall_mready", bus.m_axil_rready, 4'b0000);
    tick();
    chk("t4_held_data",  bus.s_axil_rdata, 32'hA0A0A0A0);
    chk("t4_held_vld",   bus.s_axil_rvalid, 1'b1);
    chk("t4_held_count", bus.cmd_count, 3'd3);
    bus.s_axil_rready = 1'b1;
    tick();
    chk("t4_drain_data", bus.s_axil_rdata, 32'hB0B0B0B0);
    chk("t4_drain2", bus.cmd_count, 3'd2);
    tick();
    chk("t4_drain1", bus.cmd_count, 3'd1);
    tick();
    chk("t4_drain0", bus.cmd_count, 3'd0);
    chk("t4_last_vld", bus.s_axil_rvalid, 1'b1);
    bus.m_axil_rvalid = 4'b0000;
    tick();
    chk("t4_clear", bus.s_axil_rvalid, 1'b0);

    // 5: streaming to m0 at one beat per cycle
    bus.s_rc_select = 2'd0; bus.s_rc_valid = 1'b1;
    set_m(0, 32'hC0000000, 2'b00);
    bus.m_axil_rvalid = 4'b0001;
    tick();
    chk("t5_count_first", bus.cmd_count, 3'd1);
    for (int i = 1; i <= 4; i++) begin
      set_m(0, 32'hC0000000 + 32'(i), 2'b00);
      tick();
      chk("t5_count", bus.cmd_count, 3'd1);
      chk("t5_vld",   bus.s_axil_rvalid, 1'b1);
      chk("t5_data",  bus.s_axil_rdata, 32'hC0000000 + 32'(i));
    end
    bus.s_rc_valid = 1'b0;
    tick();
    chk("t5_count_end", bus.cmd_count, 3'd0);
    bus.m_axil_rvalid = 4'b0000;
    tick();
    chk("t5_clear", bus.s_axil_rvalid, 1'b0);

    // 6: async reset with queued commands and a held beat
    bus.s_axil_rready = 1'b0;
    bus.s_rc_select = 2'd0; bus.s_rc_decerr = 1'b1; bus.s_rc_valid = 1'b1;
    tick();
    bus.s_rc_decerr = 1'b0;
    tick(); tick(); tick();
    bus.s_rc_valid = 1'b0;
    chk("t6_pre_vld",   bus.s_axil_rvalid, 1'b1);
    chk("t6_pre_count", bus.cmd_count, 3'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_vld",   bus.s_axil_rvalid, 1'b0);
    chk("t6_rst_count", bus.cmd_count, 3'd0);
    chk("t6_rst_ready", bus.s_rc_ready, 1'b1);
    chk("t6_rst_data",  bus.s_axil_rresp, 2'b00);
    tick();
    rst = 1'b0;
    bus.s_axil_rready = 1'b1;
    tick();
    chk("t6_after_vld", bus.s_axil_rvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
